// File: rtl/gate_truth_table_sequencer.sv
// Drives a two-input gate through all four {B,A} vectors, captures Y after a
// settle window per vector, and compares the captures against EXPECTED.
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      synchronous active-low reset
//   START      one-cycle run request, honoured in IDLE or DONE only
//   Y          output of the gate under control
//   A, B       gate inputs, {B,A} = current vector index
//   BUSY       high while the sequence runs
//   DONE       high from completion until the next START or reset
//   PASS       DONE with no mismatches
//   RESULT     captured Y per vector index
//   FAIL_MASK  RESULT ^ EXPECTED, valid while DONE, zero otherwise
module gate_truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  EXPECTED      = 4'b1110
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] RESULT,
    output logic [3:0] FAIL_MASK
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // Count value at which the current vector has been held long enough.
    localparam logic [7:0] LAST_COUNT = 8'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] count_q, count_d;
    logic [3:0] result_q, result_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic       pass_q, pass_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] result_cap;
    logic [1:0] idx_inc;
    logic       vec_last;

    always_comb begin
        // Result vector as it will look once the current Y is captured;
        // the final verdict must include the last capture of the run.
        result_cap = result_q;
        result_cap[idx_q] = Y;
        idx_inc = idx_q + 2'd1;
        vec_last = (count_q == LAST_COUNT);

        state_d = state_q;
        idx_d = idx_q;
        count_d = count_q;
        result_d = result_q;
        fail_mask_d = fail_mask_q;
        pass_d = pass_q;
        a_d = a_q;
        b_d = b_q;
        busy_d = busy_q;
        done_d = done_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_RUN;
                    idx_d = 2'd0;
                    count_d = 8'd0;
                    result_d = 4'd0;
                    fail_mask_d = 4'd0;
                    pass_d = 1'b0;
                    a_d = 1'b0;
                    b_d = 1'b0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                end
            end
            S_RUN: begin
                if (vec_last) begin
                    result_d = result_cap;
                    count_d = 8'd0;
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                        idx_d = 2'd0;
                        fail_mask_d = result_cap ^ EXPECTED;
                        pass_d = (result_cap == EXPECTED);
                        a_d = 1'b0;
                        b_d = 1'b0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                        a_d = idx_inc[0];
                        b_d = idx_inc[1];
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d = 2'd0;
                count_d = 8'd0;
                result_d = 4'd0;
                fail_mask_d = 4'd0;
                pass_d = 1'b0;
                a_d = 1'b0;
                b_d = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q <= 2'd0;
            count_q <= 8'd0;
            result_q <= 4'd0;
            fail_mask_q <= 4'd0;
            pass_q <= 1'b0;
            a_q <= 1'b0;
            b_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            count_q <= count_d;
            result_q <= result_d;
            fail_mask_q <= fail_mask_d;
            pass_q <= pass_d;
            a_q <= a_d;
            b_q <= b_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign A = a_q;
    assign B = b_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign PASS = pass_q;
    assign RESULT = result_q;
    assign FAIL_MASK = fail_mask_q;

endmodule

// File: doc/gate_truth_table_sequencer.md
# gate_truth_table_sequencer

Self-checking stimulus controller for a two-input combinational gate (OR, AND, XOR, …). On a START pulse it drives the gate's A/B inputs through all four input combinations, holds each for a settle window, captures the gate's Y output, and compares each capture against a parameterised expected truth table. It sits beside a gate instance and replaces the hand-written timed stimulus sequence with a clocked, repeatable sequence that reports PASS or FAIL plus the failing vector indices.

## Interface
- SETTLE_CYCLES, 4: clock cycles each vector is held before Y is sampled; legal range 1..255.
- EXPECTED, 4'b1110: expected Y per vector index i, where EXPECTED[i] is the expected Y. The default is OR.
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous and active-low.
- START  input  1  single-cycle request to run the sequence; honoured only in IDLE or DONE.
- Y  input  1  output of the gate under control.
- A  output  1  gate input A.
- B  output  1  gate input B.
- BUSY  output  1  high while a sequence is running.
- DONE  output  1  high from sequence completion until the next START or reset.
- PASS  output  1  DONE and no mismatches.
- RESULT  output  4  captured Y, where RESULT[i] is the capture for vector i.
- FAIL_MASK  output  4  RESULT XOR EXPECTED; valid when DONE=1, zero otherwise.

## Operation
- States:
  - IDLE: A=B=0, BUSY=0, DONE=0.
  - RUN: drives vector idx, counts settle cycles.
  - DONE: A=B=0, BUSY=0, DONE=1, results held.
- Vector order, with idx 2 bits and {B,A}=idx:
  - idx 0: A=0, B=0.
  - idx 1: A=1, B=0.
  - idx 2: A=0, B=1.
  - idx 3: A=1, B=1.
- IDLE/DONE + START=1 → RUN with idx=0 and count=0. RESULT and FAIL_MASK clear to 0, PASS=0 and DONE=0 in the same cycle.
- RUN:
  - count increments each cycle.
  - When count = SETTLE_CYCLES−1, Y is captured into RESULT[idx] at that edge and count resets to 0.
  - If idx<3, idx increments. Otherwise the block goes to DONE.
- FAIL_MASK and PASS are registered at the transition into DONE:
  - FAIL_MASK = RESULT ^ EXPECTED, including the final capture.
  - PASS = (FAIL_MASK == 0).
- START while in RUN is ignored; the sequence is not restarted or extended.
- START in DONE restarts the sequence and clears the previous results.
- Reset (RST_N=0 at an edge) from any state, including mid-RUN:
  - The block goes to IDLE.
  - A=0, B=0, BUSY=0, DONE=0, PASS=0, RESULT=0, FAIL_MASK=0.
  - idx and count clear to 0.
- Reset takes priority over START in the same cycle.
- The count register is wide enough for SETTLE_CYCLES−1, i.e. 8 bits maximum. idx wraps only via the DONE transition and never increments past 3.

## Timing
- START sampled at edge t0: from after t0, A/B show vector 0 and BUSY=1.
- Each vector is driven for exactly SETTLE_CYCLES cycles.
- Y for vector i is sampled at edge t0 + (i+1)·SETTLE_CYCLES.
- A/B change to vector i+1 immediately after that same edge. The gate must be stable within SETTLE_CYCLES cycles.
- After edge t0 + 4·SETTLE_CYCLES: BUSY=0, DONE=1, PASS/FAIL_MASK valid, A=B=0.
- Total BUSY duration is 4·SETTLE_CYCLES cycles.
- Outputs are registered, with no combinational path from Y or START to any output.
- Back-to-back runs: START asserted in the first DONE cycle begins the next run on the following edge.

## Test plan
- OR gate attached, default parameters; pulse START:
  - A/B step 00→10→01→11, 4 cycles each.
  - After 16 cycles DONE=1, RESULT=4'b1110, FAIL_MASK=0, PASS=1.
- Y tied to 0, default EXPECTED:
  - RESULT=4'b0000, FAIL_MASK=4'b1110, PASS=0, DONE=1.
- AND gate attached, EXPECTED=4'b1110:
  - RESULT=4'b1000, FAIL_MASK=4'b0110, PASS=0.
  - Rerun with EXPECTED=4'b1000 gives PASS=1.
- Reset mid-run: OR gate attached; START, then RST_N=0 for one cycle at cycle 6 (during vector 1):
  - Next cycle all outputs are 0 and the block is in IDLE.
  - A later START completes normally with PASS=1.
- START pulsed again at cycles 3 and 9 of a run:
  - Ignored; DONE asserts at cycle 16 exactly.
  - START in DONE clears RESULT to 0 on the next edge and reruns.
- SETTLE_CYCLES=1, OR gate:
  - A/B change every cycle.
  - DONE after 4 cycles, RESULT=4'b1110, PASS=1.
